// File: rtl/key_pkg.sv
// Shared types and constants for the push-button conditioner.
package key_pkg;

    typedef enum logic [1:0] {
        UP        = 2'd0,
        WAIT_DOWN = 2'd1,
        DOWN      = 2'd2,
        WAIT_UP   = 2'd3
    } key_state_e;

    localparam int   DEBOUNCE_50MHZ_10MS = 500000;
    localparam logic KEY_RELEASED        = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchronizer, debounce counter/FSM, and
// registered level and press/release strobes.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_10MS,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic clr,
    input  logic ie_i,
    input  logic key_raw_i,
    output logic key_clean_o,
    output logic key_press_o,
    output logic key_release_o,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s;
    logic [1:0]       sync_q;
    logic             sync;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, press_q, release_q, busy_q;
    logic             clean_d, press_d, release_d, busy_d;

    // A disabled input looks exactly like a released key.
    assign s    = ie_i ? KEY_RELEASED : key_raw_i;
    assign sync = sync_q[1];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], s};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            UP: begin
                if (!sync) begin
                    state_d = WAIT_DOWN;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_DOWN: begin
                if (sync) begin
                    state_d = UP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DOWN: begin
                if (sync) begin
                    state_d = WAIT_UP;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_UP: begin
                if (!sync) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = UP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = UP;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with it.
    always_comb begin
        clean_d   = !(state_d == DOWN || state_d == WAIT_UP);
        press_d   = (state_q == WAIT_DOWN) && (state_d == DOWN);
        release_d = (state_q == WAIT_UP) && (state_d == UP);
        busy_d    = (state_d == WAIT_DOWN) || (state_d == WAIT_UP);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= UP;
            cnt_q     <= '0;
            clean_q   <= KEY_RELEASED;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
            busy_q    <= busy_d;
        end
    end

    assign key_clean_o   = clean_q;
    assign key_press_o   = press_q;
    assign key_release_o = release_q;
    assign busy_o        = busy_q;

endmodule

// File: rtl/key_conditioner.sv
// Debounced front-end for the active-low board push-buttons; KEY_clean
// feeds the clock manager and the other control modules.
module key_conditioner
    import key_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_10MS,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              IE,
    input  logic [N_KEYS-1:0] KEY_raw,
    output logic [N_KEYS-1:0] KEY_clean,
    output logic [N_KEYS-1:0] KEY_press,
    output logic [N_KEYS-1:0] KEY_release,
    output logic              busy
);

    logic [N_KEYS-1:0] busy_w;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_key (
            .clk          (clk),
            .clr          (clr),
            .ie_i         (IE),
            .key_raw_i    (KEY_raw[i]),
            .key_clean_o  (KEY_clean[i]),
            .key_press_o  (KEY_press[i]),
            .key_release_o(KEY_release[i]),
            .busy_o       (busy_w[i])
        );
    end

    assign busy = |busy_w;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a short debounce window.
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       clr;
    logic       IE;
    logic [3:0] KEY_raw;
    logic [3:0] KEY_clean;
    logic [3:0] KEY_press;
    logic [3:0] KEY_release;
    logic       busy;

    int errs   = 0;
    int checks = 0;

    key_conditioner #(
        .N_KEYS         (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .IE         (IE),
        .KEY_raw    (KEY_raw),
        .KEY_clean  (KEY_clean),
        .KEY_press  (KEY_press),
        .KEY_release(KEY_release),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        clr     = 1'b0;
        IE      = 1'b0;
        KEY_raw = 4'hF;
        #12;
        chk("rst_clean", 32'(KEY_clean), 32'hF);
        chk("rst_press", 32'(KEY_press), 32'h0);
        chk("rst_rel", 32'(KEY_release), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        tick();
        clr = 1'b1;
        repeat (4) tick();

        // clean press and release on key 0
        KEY_raw[0] = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            tick();
            chk("t1_press", 32'(KEY_press[0]), 32'(e == 6));
            chk("t1_clean", 32'(KEY_clean[0]), 32'(e < 6));
            chk("t1_busy", 32'(busy), 32'(e >= 2 && e <= 5));
        end
        repeat (14) tick();
        KEY_raw[0] = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            tick();
            chk("t1_rel", 32'(KEY_release[0]), 32'(e == 6));
            chk("t1_rclean", 32'(KEY_clean[0]), 32'(e >= 6));
            chk("t1_rbusy", 32'(busy), 32'(e >= 2 && e <= 5));
        end
        repeat (4) tick();

        // bounce on key 1: glitch high at sample 2
        for (int e = 0; e <= 12; e++) begin
            KEY_raw[1] = (e == 2);
            tick();
            chk("t2_press", 32'(KEY_press[1]), 32'(e == 9));
            chk("t2_clean", 32'(KEY_clean[1]), 32'(e < 9));
        end
        KEY_raw[1] = 1'b1;
        repeat (10) tick();

        // short glitch on key 2
        for (int e = 0; e <= 11; e++) begin
            KEY_raw[2] = (e >= 3);
            tick();
            chk("t3_k2", 32'({KEY_clean[2], KEY_press[2], KEY_release[2]}),
                32'h4);
        end
        repeat (4) tick();

        // IE gating on key 3
        KEY_raw[3] = 1'b0;
        repeat (8) tick();
        chk("t4_held", 32'(KEY_clean[3]), 32'h0);
        IE = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            tick();
            chk("t4_rel", 32'(KEY_release[3]), 32'(e == 6));
            chk("t4_clean", 32'(KEY_clean[3]), 32'(e >= 6));
        end
        for (int e = 0; e <= 11; e++) begin
            KEY_raw[3] = e[0];
            tick();
            chk("t4_gpress", 32'(KEY_press), 32'h0);
            chk("t4_gclean", 32'(KEY_clean), 32'hF);
        end
        KEY_raw[3] = 1'b1;
        IE = 1'b0;
        repeat (8) tick();

        // simultaneous press on all keys
        KEY_raw = 4'h0;
        for (int e = 0; e <= 8; e++) begin
            tick();
            chk("t5_press", 32'(KEY_press), (e == 6) ? 32'hF : 32'h0);
        end
        repeat (4) tick();

        // reset in the middle of WAIT_UP, keys held again through reset
        KEY_raw = 4'hF;
        repeat (3) tick();
        chk("t5_waitup", 32'(busy), 32'h1);
        KEY_raw = 4'h0;
        clr = 1'b0;
        #1;
        chk("t5_rclean", 32'(KEY_clean), 32'hF);
        chk("t5_rpress", 32'(KEY_press), 32'h0);
        chk("t5_rrel", 32'(KEY_release), 32'h0);
        chk("t5_rbusy", 32'(busy), 32'h0);
        repeat (2) tick();
        clr = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            tick();
            chk("t5_ppress", 32'(KEY_press), (e == 6) ? 32'hF : 32'h0);
            chk("t5_prel", 32'(KEY_release), 32'h0);
            chk("t5_pclean", 32'(KEY_clean), (e >= 6) ? 32'h0 : 32'hF);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
